// File: rtl/lfsr_decrypt_engine_if.sv
// Start/Ack handshake, shared data-memory port and result signals of the LFSR decrypt engine.
interface lfsr_decrypt_engine_if;
    logic       start;
    logic       ack;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;
    logic [3:0] ptrn_idx;
    logic [6:0] seed;
    logic [6:0] parity_errs;
    logic       fail;

    modport master (
        input  start, mem_rd_data,
        output ack, mem_addr, mem_wr_en, mem_wr_data, ptrn_idx, seed, parity_errs, fail
    );
    modport slave (
        output start, mem_rd_data,
        input  ack, mem_addr, mem_wr_en, mem_wr_data, ptrn_idx, seed, parity_errs, fail
    );
endinterface

// File: rtl/lfsr_decrypt_engine.sv
// Recovers LFSR seed/taps from the all-space preamble of a 64-byte ciphertext at 64..127
// and writes the decrypted ASCII message to 0..63.
module lfsr_decrypt_engine (
    input  logic                  clk,
    input  logic                  rst,
    lfsr_decrypt_engine_if.master bus
);
    // state   | meaning
    // IDLE    | quiescent, waits for start=0
    // LOAD    | reads preamble bytes 64..73 into pre_buf
    // SEARCH  | tries taps 0..8 against the preamble, one compare per cycle
    // DECRYPT | per byte: read cycle, then write cycle
    // DONE    | ack high until start returns to 1
    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DECRYPT, DONE} state_t;

    state_t     state, state_d;
    logic [6:0] pre_buf [10];
    logic [6:0] lfsr;
    logic [3:0] k_idx;
    logic [5:0] idx;
    logic       ack_q, wr_en_q, fail_q;
    logic [7:0] addr_q;
    logic [3:0] ptrn_q;
    logic [6:0] seed_q, perr_q;
    logic [6:0] search_next;
    logic       search_hit, parity_bad;
    logic [7:0] plain_byte;

    function automatic logic [6:0] tap_of(input logic [3:0] k);
        case (k)
            4'd0:    tap_of = 7'h60;
            4'd1:    tap_of = 7'h48;
            4'd2:    tap_of = 7'h78;
            4'd3:    tap_of = 7'h72;
            4'd4:    tap_of = 7'h6A;
            4'd5:    tap_of = 7'h69;
            4'd6:    tap_of = 7'h5C;
            4'd7:    tap_of = 7'h7E;
            4'd8:    tap_of = 7'h7B;
            default: tap_of = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] taps);
        lfsr_step = {s[5:0], ^(s & taps)};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d     = state;
        search_next = lfsr_step(lfsr, tap_of(k_idx));
        search_hit  = (search_next == pre_buf[idx[3:0]]);
        parity_bad  = bus.mem_rd_data[7] ^ (^bus.mem_rd_data[6:0]);
        plain_byte  = {1'b0, bus.mem_rd_data[6:0] ^ lfsr} + 8'h20;
        case (state)
            IDLE:    if (!bus.start && !ack_q) state_d = LOAD;
            LOAD:    if (idx == 6'd10) state_d = (pre_buf[0] == 7'd0) ? DONE : SEARCH;
            SEARCH: begin
                if (search_hit && idx == 6'd9)        state_d = DECRYPT;
                else if (!search_hit && k_idx == 4'd8) state_d = DONE;
            end
            DECRYPT: if (wr_en_q && idx == 6'd63) state_d = DONE;
            DONE:    if (bus.start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            addr_q  <= 8'd0;
            wr_en_q <= 1'b0;
            ptrn_q  <= 4'd0;
            seed_q  <= 7'd0;
            perr_q  <= 7'd0;
            fail_q  <= 1'b0;
            lfsr    <= 7'd0;
            k_idx   <= 4'd0;
            idx     <= 6'd0;
            for (int j = 0; j < 10; j++) pre_buf[j] <= 7'd0;
        end else begin
            case (state)
                IDLE: if (state_d == LOAD) begin
                    ptrn_q <= 4'd0;
                    seed_q <= 7'd0;
                    perr_q <= 7'd0;
                    fail_q <= 1'b0;
                    addr_q <= 8'd64;
                    idx    <= 6'd0;
                end
                LOAD: begin
                    // read data lags the address by one cycle, so entry j-1 lands at count j
                    if (idx != 6'd0) pre_buf[idx[3:0] - 4'd1] <= bus.mem_rd_data[6:0];
                    if (idx == 6'd1) seed_q <= bus.mem_rd_data[6:0];
                    if (idx < 6'd9)  addr_q <= addr_q + 8'd1;
                    idx <= idx + 6'd1;
                    if (idx == 6'd10) begin
                        lfsr   <= pre_buf[0];
                        k_idx  <= 4'd0;
                        idx    <= 6'd1;
                        addr_q <= 8'd0;
                        if (pre_buf[0] == 7'd0) begin
                            fail_q <= 1'b1;
                            ptrn_q <= 4'hF;
                            ack_q  <= 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (search_hit) begin
                        lfsr <= search_next;
                        idx  <= idx + 6'd1;
                        if (idx == 6'd9) begin
                            ptrn_q <= k_idx;
                            lfsr   <= seed_q;
                            idx    <= 6'd0;
                            addr_q <= 8'd64;
                        end
                    end else begin
                        lfsr  <= pre_buf[0];
                        idx   <= 6'd1;
                        k_idx <= k_idx + 4'd1;
                        if (k_idx == 4'd8) begin
                            fail_q <= 1'b1;
                            ptrn_q <= 4'hF;
                            ack_q  <= 1'b1;
                        end
                    end
                end
                DECRYPT: begin
                    if (!wr_en_q) begin
                        wr_en_q <= 1'b1;
                        addr_q  <= {2'b00, idx};
                    end else begin
                        wr_en_q <= 1'b0;
                        if (parity_bad && perr_q != 7'h7F) perr_q <= perr_q + 7'd1;
                        lfsr   <= lfsr_step(lfsr, tap_of(ptrn_q));
                        idx    <= idx + 6'd1;
                        addr_q <= 8'd65 + {2'b00, idx};
                        if (idx == 6'd63) begin
                            ack_q  <= 1'b1;
                            addr_q <= 8'd0;
                        end
                    end
                end
                DONE: if (bus.start) ack_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // write data is formed from the read data still held on the port during the write cycle
    assign bus.mem_wr_data = wr_en_q ? plain_byte : 8'h00;
    assign bus.ack         = ack_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.ptrn_idx    = ptrn_q;
    assign bus.seed        = seed_q;
    assign bus.parity_errs = perr_q;
    assign bus.fail        = fail_q;
endmodule
